// File: rtl/a3000_rom_emulator_core.sv
// A3000 flash-backed ROM emulator core: ARM ROM pass-through plus a 64-bit SPI-slave
// link that lets an MCU take over the flash for single-word reads and writes. Macro: MISO_TRISTATE_EN.
module a3000_rom_emulator_core #(
  parameter logic [1:0] ARM_BANK    = 2'b00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        cpld_clock_osc,
  input  logic        arc_RESET,
  input  logic        cpld_clock_from_mcu,
  input  logic [19:0] rom_A,
  input  logic        rom_nCS,
  inout  wire  [31:0] rom_D,
  output logic [21:0] flash_A,
  inout  wire  [15:0] flash0_DQ,
  inout  wire  [15:0] flash1_DQ,
  output logic        flash_nCE,
  output logic        flash_nOE,
  output logic        flash_nWE,
  input  logic        cpld_SS,
  input  logic        cpld_SCK,
  input  logic        cpld_MOSI,
  output logic        cpld_MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  logic                   unused_clk_from_mcu;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall;
  logic [6:0]             bit_cnt_q;
  logic [55:0]            shift_in_q;
  logic [31:0]            out_q;
  logic                   miso_q;
  logic                   allowing_arm_access;
  state_t                 state_q, state_d;
  logic [21:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   capture;
  logic                   mcu_nce, mcu_noe, mcu_nwe, mcu_dq_oe;

  assign unused_clk_from_mcu = cpld_clock_from_mcu;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  always_ff @(posedge cpld_clock_osc or negedge arc_RESET) begin
    if (!arc_RESET) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], cpld_SCK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], cpld_SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], cpld_MOSI};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  // The very first bit of a frame decides who owns the flash; later bits only feed the shifter.
  always_ff @(posedge cpld_clock_osc or negedge arc_RESET) begin
    if (!arc_RESET) begin
      bit_cnt_q           <= '0;
      shift_in_q          <= '0;
      out_q               <= '0;
      miso_q              <= 1'b0;
      allowing_arm_access <= 1'b1;
      state_q             <= ST_IDLE;
      addr_q              <= '0;
      data_q              <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (ss_fall) begin
        bit_cnt_q  <= '0;
        shift_in_q <= '0;
        out_q      <= '0;
        miso_q     <= 1'b0;
      end else if (ss_s) begin
        out_q  <= '0;
        miso_q <= 1'b0;
      end else begin
        if (sck_rise && (bit_cnt_q < 7'd64)) begin
          shift_in_q <= {shift_in_q[54:0], mosi_s};
          bit_cnt_q  <= bit_cnt_q + 7'd1;
          if (bit_cnt_q == 7'd0) begin
            allowing_arm_access <= mosi_s;
          end
        end
        if (capture) begin
          out_q <= {flash1_DQ, flash0_DQ};
        end else if (sck_fall) begin
          miso_q <= out_q[31];
          out_q  <= {out_q[30:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    capture   = 1'b0;
    mcu_nce   = 1'b1;
    mcu_noe   = 1'b1;
    mcu_nwe   = 1'b1;
    mcu_dq_oe = 1'b0;
    // A stale count is still visible on the clock that sees SS fall, so treat that clock as idle too.
    if (ss_s || ss_fall) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bit_cnt_q == 7'd24 && !shift_in_q[23] && shift_in_q[22]) begin
            state_d = ST_READ;
            addr_d  = shift_in_q[21:0];
          end else if (bit_cnt_q == 7'd56 && !shift_in_q[55] && !shift_in_q[54]) begin
            state_d = ST_WR_SETUP;
            addr_d  = shift_in_q[53:32];
            data_d  = shift_in_q[31:0];
          end
        end
        ST_READ: begin
          mcu_nce = 1'b0;
          mcu_noe = 1'b0;
          if (bit_cnt_q >= 7'd32) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_WR_SETUP: begin
          mcu_nce   = 1'b0;
          mcu_dq_oe = 1'b1;
          if (bit_cnt_q >= 7'd58) state_d = ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          mcu_nce   = 1'b0;
          mcu_nwe   = 1'b0;
          mcu_dq_oe = 1'b1;
          if (bit_cnt_q >= 7'd62) state_d = ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          mcu_nce   = 1'b0;
          mcu_dq_oe = 1'b1;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset forces every strobe high even though ownership defaults to the ARM.
  assign flash_A   = allowing_arm_access ? {ARM_BANK, rom_A} : addr_q;
  assign flash_nCE = ~arc_RESET | (allowing_arm_access ? rom_nCS : mcu_nce);
  assign flash_nOE = ~arc_RESET | (allowing_arm_access ? rom_nCS : mcu_noe);
  assign flash_nWE = ~arc_RESET | allowing_arm_access | mcu_nwe;

  assign flash0_DQ = (arc_RESET && !allowing_arm_access && mcu_dq_oe) ? data_q[15:0]  : 16'bz;
  assign flash1_DQ = (arc_RESET && !allowing_arm_access && mcu_dq_oe) ? data_q[31:16] : 16'bz;
  assign rom_D     = (arc_RESET && allowing_arm_access && !rom_nCS) ? {flash1_DQ, flash0_DQ} : 32'bz;

`ifdef MISO_TRISTATE_EN
  assign cpld_MISO = ss_s ? 1'bz : miso_q;
`else
  assign cpld_MISO = miso_q;
`endif

endmodule

// File: tb/tb_a3000_rom_emulator_core.sv
// Self-checking bench for a3000_rom_emulator_core: SPI frames from a modelled MCU,
// a simple flash model, and a scoreboard of expected flash cycles.
module tb_a3000_rom_emulator_core;

  typedef struct packed {
    logic        isWr;
    logic [21:0] addr;
    logic [31:0] data;
  } cyc_t;

  logic        clock = 1'b0;
  logic        arcReset = 1'b0;
  logic [19:0] romA = '0;
  logic        romNcs = 1'b1;
  wire  [31:0] romD;
  wire  [21:0] flashA;
  wire  [15:0] flash0Dq;
  wire  [15:0] flash1Dq;
  wire         flashNce, flashNoe, flashNwe;
  logic        cpldSs = 1'b1;
  logic        cpldSck = 1'b0;
  logic        cpldMosi = 1'b0;
  wire         cpldMiso;

  int          nCompared = 0;
  int          nMismatched = 0;
  cyc_t        expQ[$];
  cyc_t        obsQ[$];
  int          rdIdx = 0;
  cyc_t        expC;
  bit          monEn = 1'b0;
  logic [63:0] rx;
  logic [31:0] flashModel;

  a3000_rom_emulator_core dut (
    .cpld_clock_osc      (clock),
    .arc_RESET           (arcReset),
    .cpld_clock_from_mcu (1'b0),
    .rom_A               (romA),
    .rom_nCS             (romNcs),
    .rom_D               (romD),
    .flash_A             (flashA),
    .flash0_DQ           (flash0Dq),
    .flash1_DQ           (flash1Dq),
    .flash_nCE           (flashNce),
    .flash_nOE           (flashNoe),
    .flash_nWE           (flashNwe),
    .cpld_SS             (cpldSs),
    .cpld_SCK            (cpldSck),
    .cpld_MOSI           (cpldMosi),
    .cpld_MISO           (cpldMiso)
  );

  always #5 clock = ~clock;

  // Flash model: each word reads back a marker in the top bits and its own address below.
  assign flashModel = {10'b1010101010, flashA};
  assign flash0Dq = (!flashNce && !flashNoe) ? flashModel[15:0]  : 16'bz;
  assign flash1Dq = (!flashNce && !flashNoe) ? flashModel[31:16] : 16'bz;

  always @(negedge flashNwe) begin
    if (monEn) begin
      #1;
      obsQ.push_back({1'b1, flashA, flash1Dq, flash0Dq});
    end
  end

  always @(negedge flashNoe) begin
    if (monEn && !dut.allowing_arm_access) begin
      #1;
      obsQ.push_back({1'b0, flashA, 32'h0});
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_xfer(input logic [63:0] tx, input int nbits, input bit raiseSs,
                          output logic [63:0] rxOut);
    rxOut = '0;
    cpldSs = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < nbits; i++) begin
      cpldMosi = tx[63-i];
      repeat (5) @(posedge clock);
      #1;
      rxOut[63-i] = cpldMiso;
      cpldSck = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      cpldSck = 1'b0;
    end
    repeat (5) @(posedge clock);
    #1;
    if (raiseSs) begin
      cpldSs = 1'b1;
      repeat (8) @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    arcReset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    nCompared++;
    if ({flashNce, flashNoe, flashNwe} !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL reset_strobes: got %b required %b", {flashNce, flashNoe, flashNwe}, 3'b111);
    end
    nCompared++;
    if (cpldMiso !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_miso: got %b required 0", cpldMiso);
    end
    arcReset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    monEn = 1'b1;
    nCompared++;
    if (dut.allowing_arm_access !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_arm_access: got %b required 1", dut.allowing_arm_access);
    end
  endtask

  task automatic test_arm_passthrough();
    romA = 20'h12345;
    romNcs = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nCompared++;
    if (flashA !== 22'h012345) begin
      nMismatched++;
      $display("[TB] FAIL arm_flash_a: got %h required %h", flashA, 22'h012345);
    end
    nCompared++;
    if ({flashNce, flashNoe, flashNwe} !== 3'b001) begin
      nMismatched++;
      $display("[TB] FAIL arm_strobes: got %b required %b", {flashNce, flashNoe, flashNwe}, 3'b001);
    end
    nCompared++;
    if (romD !== 32'haa812345) begin
      nMismatched++;
      $display("[TB] FAIL arm_rom_d: got %h required %h", romD, 32'haa812345);
    end
    romNcs = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    nCompared++;
    if ({flashNce, flashNoe} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL arm_deselect: got %b required %b", {flashNce, flashNoe}, 2'b11);
    end
  endtask

  task automatic test_access_switch();
    expQ.push_back({1'b0, 22'h3fffff, 32'h0});
    spi_xfer(64'h7fffffffffffffff, 64, 1'b1, rx);
    nCompared++;
    if (dut.allowing_arm_access !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL take_flash: got %b required 0", dut.allowing_arm_access);
    end
    nCompared++;
    if (rx[31:0] !== 32'haabfffff) begin
      nMismatched++;
      $display("[TB] FAIL take_flash_read: got %h required %h", rx[31:0], 32'haabfffff);
    end
    spi_xfer(64'hffffffffffffffff, 64, 1'b1, rx);
    nCompared++;
    if (dut.allowing_arm_access !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL give_flash: got %b required 1", dut.allowing_arm_access);
    end
    romA = 20'habcde;
    romNcs = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nCompared++;
    if (romD !== 32'haa8abcde) begin
      nMismatched++;
      $display("[TB] FAIL give_flash_rom_d: got %h required %h", romD, 32'haa8abcde);
    end
    romNcs = 1'b1;
    while (expQ.size() > 0) begin
      expC = expQ.pop_front();
      nCompared++;
      if (rdIdx >= obsQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL switch_cycle: got none required %h", expC);
      end else begin
        if (obsQ[rdIdx] !== expC) begin
          nMismatched++;
          $display("[TB] FAIL switch_cycle: got %h required %h", obsQ[rdIdx], expC);
        end
        rdIdx++;
      end
    end
    nCompared++;
    if (obsQ.size() != rdIdx) begin
      nMismatched++;
      $display("[TB] FAIL switch_extra_cycles: got %0d required 0", obsQ.size() - rdIdx);
      rdIdx = obsQ.size();
    end
  endtask

  task automatic test_write();
    expQ.push_back({1'b1, 22'h051234, 32'h12345678});
    spi_xfer({1'b0, 1'b0, 22'h051234, 32'h12345678, 8'h00}, 64, 1'b1, rx);
    nCompared++;
    if (dut.allowing_arm_access !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL write_arm_access: got %b required 0", dut.allowing_arm_access);
    end
    nCompared++;
    if ({flashNce, flashNoe, flashNwe} !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL write_idle_strobes: got %b required %b", {flashNce, flashNoe, flashNwe}, 3'b111);
    end
    while (expQ.size() > 0) begin
      expC = expQ.pop_front();
      nCompared++;
      if (rdIdx >= obsQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL write_cycle: got none required %h", expC);
      end else begin
        if (obsQ[rdIdx] !== expC) begin
          nMismatched++;
          $display("[TB] FAIL write_cycle: got %h required %h", obsQ[rdIdx], expC);
        end
        rdIdx++;
      end
    end
    nCompared++;
    if (obsQ.size() != rdIdx) begin
      nMismatched++;
      $display("[TB] FAIL write_extra_cycles: got %0d required 0", obsQ.size() - rdIdx);
      rdIdx = obsQ.size();
    end
  endtask

  task automatic test_read();
    expQ.push_back({1'b0, 22'h070f0f, 32'h0});
    spi_xfer({1'b0, 1'b1, 22'h070f0f, 40'h0}, 64, 1'b1, rx);
    nCompared++;
    if (rx !== 64'h00000000aa870f0f) begin
      nMismatched++;
      $display("[TB] FAIL read_miso: got %h required %h", rx, 64'h00000000aa870f0f);
    end
    while (expQ.size() > 0) begin
      expC = expQ.pop_front();
      nCompared++;
      if (rdIdx >= obsQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL read_cycle: got none required %h", expC);
      end else begin
        if (obsQ[rdIdx] !== expC) begin
          nMismatched++;
          $display("[TB] FAIL read_cycle: got %h required %h", obsQ[rdIdx], expC);
        end
        rdIdx++;
      end
    end
    nCompared++;
    if (obsQ.size() != rdIdx) begin
      nMismatched++;
      $display("[TB] FAIL read_extra_cycles: got %0d required 0", obsQ.size() - rdIdx);
      rdIdx = obsQ.size();
    end
  endtask

  task automatic test_back_to_back();
    cyc_t seq[6];
    logic [31:0] rdExp;
    seq[0] = {1'b1, 22'h005555, 32'h000000aa};
    seq[1] = {1'b1, 22'h002aaa, 32'h00000055};
    seq[2] = {1'b1, 22'h005555, 32'h00000090};
    seq[3] = {1'b0, 22'h000000, 32'h0};
    seq[4] = {1'b0, 22'h000001, 32'h0};
    seq[5] = {1'b1, 22'h005555, 32'h000000f0};
    for (int k = 0; k < 6; k++) begin
      expQ.push_back(seq[k]);
      spi_xfer({1'b0, ~seq[k].isWr, seq[k].addr, seq[k].data, 8'h00}, 64, 1'b1, rx);
      if (!seq[k].isWr) begin
        rdExp = {10'b1010101010, seq[k].addr};
        nCompared++;
        if (rx[31:0] !== rdExp) begin
          nMismatched++;
          $display("[TB] FAIL unlock_read%0d: got %h required %h", k, rx[31:0], rdExp);
        end
      end
    end
    while (expQ.size() > 0) begin
      expC = expQ.pop_front();
      nCompared++;
      if (rdIdx >= obsQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL unlock_cycle: got none required %h", expC);
      end else begin
        if (obsQ[rdIdx] !== expC) begin
          nMismatched++;
          $display("[TB] FAIL unlock_cycle: got %h required %h", obsQ[rdIdx], expC);
        end
        rdIdx++;
      end
    end
    nCompared++;
    if (obsQ.size() != rdIdx) begin
      nMismatched++;
      $display("[TB] FAIL unlock_extra_cycles: got %0d required 0", obsQ.size() - rdIdx);
      rdIdx = obsQ.size();
    end
  endtask

  task automatic test_abort();
    spi_xfer({1'b0, 1'b0, 22'h012121, 32'hdeadbeef, 8'h00}, 40, 1'b1, rx);
    nCompared++;
    if ({flashNce, flashNoe, flashNwe} !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL abort_strobes: got %b required %b", {flashNce, flashNoe, flashNwe}, 3'b111);
    end
    nCompared++;
    if (dut.allowing_arm_access !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL abort_arm_access: got %b required 0", dut.allowing_arm_access);
    end
    expQ.push_back({1'b0, 22'h000123, 32'h0});
    spi_xfer({1'b0, 1'b1, 22'h000123, 40'h0}, 28, 1'b0, rx);
    nCompared++;
    if ({flashNce, flashNoe} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL midread_active: got %b required %b", {flashNce, flashNoe}, 2'b00);
    end
    arcReset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nCompared++;
    if ({flashNce, flashNoe, flashNwe, cpldMiso} !== 4'b1110) begin
      nMismatched++;
      $display("[TB] FAIL midread_reset: got %b required %b", {flashNce, flashNoe, flashNwe, cpldMiso}, 4'b1110);
    end
    arcReset = 1'b1;
    repeat (4) @(posedge clock);
    cpldSs = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    nCompared++;
    if (dut.allowing_arm_access !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL after_reset_arm_access: got %b required 1", dut.allowing_arm_access);
    end
    while (expQ.size() > 0) begin
      expC = expQ.pop_front();
      nCompared++;
      if (rdIdx >= obsQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL abort_cycle: got none required %h", expC);
      end else begin
        if (obsQ[rdIdx] !== expC) begin
          nMismatched++;
          $display("[TB] FAIL abort_cycle: got %h required %h", obsQ[rdIdx], expC);
        end
        rdIdx++;
      end
    end
    nCompared++;
    if (obsQ.size() != rdIdx) begin
      nMismatched++;
      $display("[TB] FAIL abort_extra_cycles: got %0d required 0", obsQ.size() - rdIdx);
      rdIdx = obsQ.size();
    end
  endtask

  initial begin
    $display("[TB] starting a3000_rom_emulator_core bench");
    test_reset();
    test_arm_passthrough();
    test_access_switch();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/a3000_rom_emulator_core.md
Name: a3000_rom_emulator_core

Overview:
- Flash-backed ROM emulator CPLD core for the A3000.
- Normally passes ARM ROM reads straight through to two 16-bit flash chips that form a 32-bit word.
- An MCU talks to the core over a 64-bit SPI-slave link. Through it the MCU can take the flash away from the ARM, read or program individual 32-bit flash words, and hand the flash back.

Parameters:
- ARM_BANK, 2'b00: value driven on flash_A[21:20] while the ARM owns the flash.
- SYNC_STAGES, 2: synchroniser depth for cpld_SCK, cpld_SS and cpld_MOSI (minimum 2).

Ports:
- cpld_clock_osc  in  1: the single system clock; all state is synchronous to its rising edge.
- arc_RESET  in  1: asynchronous, active-low reset.
- cpld_clock_from_mcu  in  1: reserved, ignored.
- rom_A  in  20: ARM ROM word address.
- rom_nCS  in  1: ARM ROM chip select, active-low.
- rom_D  inout  32: ARM ROM data bus.
- flash_A  out  22: flash word address.
- flash0_DQ  inout  16: flash data bits [15:0].
- flash1_DQ  inout  16: flash data bits [31:16].
- flash_nCE, flash_nOE, flash_nWE  out  1 each: flash strobes, active-low.
- cpld_SS  in  1: SPI slave select, active-low.
- cpld_SCK  in  1: SPI clock, mode 0.
- cpld_MOSI  in  1: SPI data from the MCU.
- cpld_MISO  out  1: SPI data to the MCU.

Behaviour:
- Internal register allowing_arm_access; reset value 1. Verification probes it by this name.
- ARM mode (allowing_arm_access=1), combinational:
  - flash_A = {ARM_BANK, rom_A}.
  - flash_nCE = flash_nOE = rom_nCS; flash_nWE = 1.
  - flash DQ released (Z).
  - rom_D = {flash1_DQ, flash0_DQ} when rom_nCS=0, else Z.
- MCU mode (allowing_arm_access=0):
  - rom_D = Z.
  - Flash pins driven only by the transaction logic. Idle state: nCE=nOE=nWE=1, DQ=Z, flash_A holds its last value.
- SPI input handling:
  - SCK, SS and MOSI pass through SYNC_STAGES flops; edges are detected in the clock domain.
  - The clock must run at least 4x the SCK frequency.
  - Falling SS: bit counter cleared to 0, shift register cleared.
- Each SCK rising edge while SS=0 shifts MOSI in MSB-first and increments the counter (0..64).
- Frame layout, bit 63 sent first:
  - [63] acc.
  - [62] rnw.
  - [61:40] address A[21:0].
  - [39:8] write data.
  - [7:0] zero pad.
  - On reads, the MCU receives flash data in frame bits [31:0].
- acc handling, on receipt of the first bit:
  - acc=1: allowing_arm_access<=1; the remaining bits are ignored and no flash cycle occurs.
  - acc=0: allowing_arm_access<=0; the transaction proceeds as below.
- Read (rnw=1), after 24 bits:
  - Drive flash_A=A, nCE=0, nOE=0.
  - Hold through bit 32 (8 pad bits of settling).
  - After the 32nd rising edge, latch {flash1_DQ, flash0_DQ} into the output shift register.
  - Strobes return to 1 on the next clock.
- Write (rnw=1 clear, i.e. rnw=0), after 56 bits:
  - Drive flash_A=A, DQ=data, nCE=0.
  - nWE=0 from the 58th rising edge until the 62nd rising edge, then nWE=1.
  - nCE=1 and DQ=Z when SS rises.
- cpld_MISO:
  - Updated on each SCK falling edge from the output shift register MSB.
  - Read data appears on bits 31..0 of the frame; 0 at all other times.
- Abort (SS rises before 64 bits):
  - All strobes go to 1 and DQ to Z within 1 clock after the synchronised edge.
  - allowing_arm_access keeps the value set by the first bit.
  - An incomplete write never asserts nWE. If nWE is already low, it is released immediately.
- Bits beyond 64 are ignored until SS rises.
- arc_RESET low at any time:
  - Abort any transaction, allowing_arm_access=1, counters cleared.
  - All flash strobes 1, DQ=Z, MISO=0.

Optional Feature:
- MISO_TRISTATE_EN defined: cpld_MISO is Z whenever synchronised SS=1, allowing a shared MISO line.
- Not defined: cpld_MISO is always driven, 0 when idle.

Test Plan:
- Release reset, wait 10 clocks -> allowing_arm_access=1; rom_A=12345 with rom_nCS=0 gives flash_A=012345, flash_nOE=0, rom_D=flash data.
- Frame 7fffffffffffffff -> allowing_arm_access=0, rom_D=Z; then frame ffffffffffffffff -> allowing_arm_access=1.
- Write frame {0,0,22'h51234,32'h12345678,8'h00} -> one nWE low pulse with flash_A=051234 and flash_D=12345678; ARM access stays 0.
- Read frame {0,1,22'h070f0f,40'h0}, with a flash model returning {10'b1010101010,flash_A} -> nOE pulse at flash_A=070f0f; MISO frame[31:0]=aa870f0f.
- Unlock sequence (write AA@5555, 55@2AAA, 90@5555, read 0, read 1, write F0@5555) -> exactly six flash cycles, in that order, at those addresses.
- SS raised after 40 bits of a write frame, and a separate assertion of arc_RESET mid-read -> no nWE pulse; strobes released; after reset allowing_arm_access=1.
